// File: rtl/re_slot_scheduler.sv
// re_slot_scheduler: per-slot sequencer for the PUSCH RE mapper.
// Validates and latches the slot allocation, then walks the allocated
// symbols: request DMRS/FFT data, start the mapper, wait for symbol done.
module re_slot_scheduler #(
  parameter  int unsigned TIMEOUT = 4095,
  localparam int unsigned SC_W    = 11,
  localparam int unsigned RB_W    = 7,
  localparam int unsigned SYM_W   = 4,
  localparam int unsigned MASK_W  = 14,
  localparam int unsigned WD_W    = 12,
  localparam int unsigned SUM_W   = 12
) (
  input  logic              clk_re_i,
  input  logic              rst_re_i,
  input  logic              slot_start_i,
  input  logic              abort_i,
  input  logic [SC_W-1:0]   n_sc_i,
  input  logic [RB_W-1:0]   n_rb_i,
  input  logic [SYM_W-1:0]  sym_start_i,
  input  logic [SYM_W-1:0]  sym_end_i,
  input  logic [MASK_W-1:0] dmrs_mask_i,
  output logic              dmrs_req_o,
  input  logic              dmrs_done_i,
  output logic              fft_req_o,
  input  logic              fft_done_i,
  output logic              map_start_o,
  output logic              map_is_dmrs_o,
  output logic [SYM_W-1:0]  map_sym_o,
  output logic [SC_W-1:0]   map_first_o,
  output logic [SC_W-1:0]   map_last_o,
  input  logic              map_sym_done_i,
  output logic              busy_o,
  output logic              slot_done_o,
  output logic              cfg_err_o,
  output logic              timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_START    = 3'd2,
    S_WAIT_MAP = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic [SYM_W-1:0]    end_q, end_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [SC_W-1:0]     first_q, first_d;
  logic [SC_W-1:0]     last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                busy_q, busy_d;
  logic                dmrs_req_q, dmrs_req_d;
  logic                fft_req_q, fft_req_d;
  logic                map_start_q, map_start_d;
  logic                is_dmrs_q, is_dmrs_d;
  logic                slot_done_q, slot_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                timeout_err_q, timeout_err_d;

  logic [SUM_W-1:0]    cfg_sum_c;
  logic [SC_W-1:0]     rb12_c;
  logic [SC_W-1:0]     last_c;
  logic                cfg_ok_c;
  logic                wd_expired_c;
  logic                src_done_c;

  // Configuration check and mapper bound arithmetic on the live inputs
  always_comb begin
    cfg_sum_c    = SUM_W'(n_sc_i) + SUM_W'(n_rb_i) * SUM_W'(12);
    rb12_c       = SC_W'(n_rb_i) * SC_W'(12);
    last_c       = n_sc_i + rb12_c - SC_W'(1);
    cfg_ok_c     = (sym_start_i <= sym_end_i) && (sym_end_i <= SYM_W'(13)) &&
                   (n_rb_i >= RB_W'(1)) && (n_rb_i <= RB_W'(100)) &&
                   (cfg_sum_c <= SUM_W'(1200));
    wd_expired_c = (wd_q == WD_W'(TIMEOUT - 1));
    src_done_c   = mask_q[sym_q] ? dmrs_done_i : fft_done_i;
  end

  // Next-state, latched configuration, watchdog and registered-output decode
  always_comb begin
    state_d       = state_q;
    sym_d         = sym_q;
    end_d         = end_q;
    mask_d        = mask_q;
    first_d       = first_q;
    last_d        = last_q;
    wd_d          = '0;
    cfg_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (slot_start_i) begin
            if (cfg_ok_c) begin
              sym_d   = sym_start_i;
              end_d   = sym_end_i;
              mask_d  = dmrs_mask_i;
              first_d = n_sc_i;
              last_d  = last_c;
              state_d = S_REQ;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_REQ: begin
          if (wd_expired_c) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end else if (src_done_c) begin
            state_d = S_START;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_START: begin
          state_d = S_WAIT_MAP;
        end
        S_WAIT_MAP: begin
          if (wd_expired_c) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end else if (map_sym_done_i) begin
            if (sym_q == end_q) begin
              state_d = S_DONE;
            end else begin
              sym_d   = sym_q + SYM_W'(1);
              state_d = S_REQ;
            end
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d      = (state_d != S_IDLE);
    dmrs_req_d  = (state_d == S_REQ) &&  mask_d[sym_d];
    fft_req_d   = (state_d == S_REQ) && !mask_d[sym_d];
    map_start_d = (state_d == S_START);
    slot_done_d = (state_d == S_DONE);
    is_dmrs_d   = mask_d[sym_d];
  end

  // State and output registers
  always_ff @(posedge clk_re_i) begin
    if (rst_re_i) begin
      state_q       <= S_IDLE;
      sym_q         <= '0;
      end_q         <= '0;
      mask_q        <= '0;
      first_q       <= '0;
      last_q        <= '0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      dmrs_req_q    <= 1'b0;
      fft_req_q     <= 1'b0;
      map_start_q   <= 1'b0;
      is_dmrs_q     <= 1'b0;
      slot_done_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_q         <= sym_d;
      end_q         <= end_d;
      mask_q        <= mask_d;
      first_q       <= first_d;
      last_q        <= last_d;
      wd_q          <= wd_d;
      busy_q        <= busy_d;
      dmrs_req_q    <= dmrs_req_d;
      fft_req_q     <= fft_req_d;
      map_start_q   <= map_start_d;
      is_dmrs_q     <= is_dmrs_d;
      slot_done_q   <= slot_done_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign dmrs_req_o    = dmrs_req_q;
  assign fft_req_o     = fft_req_q;
  assign map_start_o   = map_start_q;
  assign map_is_dmrs_o = is_dmrs_q;
  assign map_sym_o     = sym_q;
  assign map_first_o   = first_q;
  assign map_last_o    = last_q;
  assign busy_o        = busy_q;
  assign slot_done_o   = slot_done_q;
  assign cfg_err_o     = cfg_err_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: doc/re_slot_scheduler.md
# re_slot_scheduler

Slot-level sequencer for the PUSCH resource-element mapper. It latches and validates the per-slot allocation (N_sc, N_rb, symbol range, DMRS symbol mask), then walks the allocated OFDM symbols one at a time. For each symbol it requests data from the DMRS generator or the FFT/transform-precoder path, starts the mapper for that symbol, and waits for the mapper's symbol-done. It sits between the slot controller and the mapper, and supplies the mapper's symbol index, symbol type and subcarrier bounds.

## Interface
- TIMEOUT, 4095: maximum cycles spent waiting in REQ or WAIT_MAP before abort (12-bit watchdog).
- CLK_RE  in  1  single clock; all logic on rising edge.
- RST_RE  in  1  reset, synchronous, active-high.
- Slot_Start  in  1  one-cycle pulse; sampled only in IDLE.
- Abort  in  1  synchronous abort; any state goes to IDLE.
- N_sc  in  11  first allocated subcarrier.
- N_rb  in  7  allocated RBs.
- Sym_Start, Sym_End  in  4 each  first and last allocated symbol.
- Dmrs_Mask  in  14  bit k=1 means symbol k carries DMRS.
- Dmrs_Req  out  1  level request to DMRS generator.
- Dmrs_Done  in  1  DMRS block ready; sampled only in REQ.
- Fft_Req  out  1  level request to FFT path.
- Fft_Done  in  1  FFT symbol ready; sampled only in REQ.
- Map_Start  out  1  one-cycle pulse starting the mapper.
- Map_Is_Dmrs  out  1  type of current symbol.
- Map_Sym  out  4  current symbol index.
- Map_First, Map_Last  out  11 each  latched N_sc and N_sc+12*N_rb-1.
- Map_Sym_Done  in  1  mapper finished symbol; sampled only in WAIT_MAP.
- Busy  out  1  high in any state other than IDLE.
- Slot_Done  out  1  one-cycle pulse.
- Cfg_Err, Timeout_Err  out  1 each  one-cycle error pulses.

## Operation
- States: IDLE, REQ, START, WAIT_MAP, DONE.
- IDLE with Slot_Start:
  - Validate the configuration. It is valid when Sym_Start<=Sym_End<=13, 1<=N_rb<=100, and N_sc+12*N_rb<=1200 (computed at 12 bits, no truncation).
  - Valid: latch all configuration, set Map_Sym=Sym_Start, go to REQ.
  - Invalid: pulse Cfg_Err, stay in IDLE, leave latched values unchanged.
- REQ:
  - Assert Dmrs_Req if Dmrs_Mask[Map_Sym] is set, otherwise Fft_Req. Exactly one request is high.
  - Only the matching Done is honoured; the other Done is ignored.
  - On the matching Done, go to START.
- START: Map_Start=1 for exactly one cycle; both requests low; then go to WAIT_MAP.
- WAIT_MAP, on Map_Sym_Done:
  - If Map_Sym==Sym_End (latched), go to DONE.
  - Otherwise increment Map_Sym and go to REQ.
- DONE: Slot_Done=1 for one cycle, then go to IDLE.
- Map_Is_Dmrs = Dmrs_Mask_latched[Map_Sym], valid in every non-IDLE state.
- Map_First, Map_Last and Map_Sym hold their values in IDLE after the slot ends.
- Map_Last arithmetic: 12*N_rb computed at 11 bits (max 1200), then add and subtract 1. Validation guarantees Map_Last<=1199.
- Watchdog:
  - 12-bit counter, cleared on every state change.
  - Increments in REQ and WAIT_MAP.
  - On reaching TIMEOUT: pulse Timeout_Err, drop requests, go to IDLE, no Slot_Done.
- Priority, highest first: RST_RE > Abort > watchdog > normal transitions.
- Abort: go to IDLE next cycle, all requests and pulses low, no Slot_Done, no error pulse.
- Slot_Start outside IDLE is ignored. Done inputs outside their sampling state are ignored; they are not stored.

## Timing
- Reset values: state IDLE, all outputs 0, latched configuration 0, watchdog 0.
- All outputs are registered or decoded from state only; there are no input-to-output combinational paths.
- Slot_Start at cycle t (valid): Busy and the request go high at t+1.
- Invalid configuration: Cfg_Err high at t+1 only.
- Done at cycle u in REQ: request low and Map_Start high at u+1; WAIT_MAP from u+2.
- Map_Sym_Done at v:
  - Not the last symbol: Map_Sym updated and next request high at v+1.
  - Last symbol: Slot_Done high at v+1; Busy low at v+2.
- Minimum per-symbol overhead: 3 cycles, plus source and mapper latency.
- Done asserted in the same cycle the request rises is honoured (it is sampled in REQ).
- Abort, or RST_RE, in cycle w: IDLE and outputs cleared at w+1.

## Test plan
- Sym_Start=2, Sym_End=5, Dmrs_Mask=0x0004, N_sc=24, N_rb=4 → Map_First=24, Map_Last=71; one Dmrs_Req (symbol 2), three Fft_Req (3..5); four Map_Start pulses; Slot_Done one cycle after the 4th Map_Sym_Done.
- N_sc=1190, N_rb=1 → Cfg_Err at t+1, Busy stays 0. Sym_Start=6, Sym_End=3 → Cfg_Err.
- In REQ for a DMRS symbol, pulse Fft_Done → ignored, Dmrs_Req stays high; then Dmrs_Done → Map_Start next cycle.
- TIMEOUT=20, withhold Map_Sym_Done → Timeout_Err exactly 20 cycles after entering WAIT_MAP, then IDLE, no Slot_Done.
- Abort during WAIT_MAP on symbol 3, same cycle as Map_Sym_Done → IDLE next cycle, no Slot_Done; a following Slot_Start restarts at Sym_Start.
- Slot_Start pulsed while Busy → ignored; Sym_Start=Sym_End=13, Dmrs_Mask=0x2000 → single DMRS symbol, Slot_Done produced.
